// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and typedefs for the general-purpose
//                register file, also used by decode and write-back.
//                  NUM_REGS   number of architectural registers (power of two)
//                  XLEN       data width in bits
//                  AW         address width, log2(NUM_REGS)
//                  reg_addr_t register address type (AW bits)
//                  reg_data_t register data type (XLEN bits)
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int XLEN     = 32;
  localparam int AW       = $clog2(NUM_REGS);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_port
//  Description : One combinational read port of the register file: address
//                decode, register-0 masking and, when REGFILE_BYPASS_EN is
//                defined, write-to-read forwarding of the in-flight write.
//  Ports       : addr     in   read address
//                regs     in   committed register array contents
//                byp_we   in   forwarding qualifier (write enabled, out of
//                              reset, target not r0)  [REGFILE_BYPASS_EN only]
//                byp_addr in   write address          [REGFILE_BYPASS_EN only]
//                byp_data in   write data             [REGFILE_BYPASS_EN only]
//                rdata    out  read data
//  Config      : REGFILE_BYPASS_EN - enables same-cycle forwarding
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
  import regfile_pkg::*;
(
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] regs [NUM_REGS],
`ifdef REGFILE_BYPASS_EN
  input  logic            byp_we,
  input  logic [AW-1:0]   byp_addr,
  input  logic [XLEN-1:0] byp_data,
`endif
  output logic [XLEN-1:0] rdata
);

  always_comb begin
    rdata = '0;
    // r0 is hardwired to zero, even before the first reset, so the mask
    // sits ahead of everything else.
    if (addr != '0) begin
`ifdef REGFILE_BYPASS_EN
      if (byp_we && (byp_addr == addr)) begin
        rdata = byp_data;
      end else begin
        rdata = regs[addr];
      end
`else
      rdata = regs[addr];
`endif
    end
  end

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : 32 x 32-bit general-purpose register file with two
//                combinational read ports and one clock-edge write port.
//                Register 0 always reads as zero.
//  Ports       : clk    in   clock, state updates on rising edge
//                reset  in   synchronous active-low reset, clears all entries
//                A1     in   read address, port 1
//                A2     in   read address, port 2
//                A3     in   write address
//                WE3    in   write enable, active-high
//                WD3    in   write data
//                RD1    out  read data, port 1
//                RD2    out  read data, port 2
//  Config      : REGFILE_BYPASS_EN - when defined, a write in flight is
//                forwarded to a read port addressing the same register in
//                the same cycle (suppressed while reset is low).
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   A3,
  input  logic            WE3,
  input  logic [XLEN-1:0] WD3,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  // Writes to r0 are dropped here; entry 0 is held at zero so the array
  // never carries a stale value there after reset.
  always_comb begin
    regs_d = regs_q;
    if (WE3 && (A3 != '0)) begin
      regs_d[A3] = WD3;
    end
    regs_d[0] = '0;
  end

  // Reset has priority over a simultaneous write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_we;

  // Forwarding is only meaningful for a write that will actually commit.
  assign byp_we = WE3 && reset && (A3 != '0);
`endif

  regfile_read_port u_read_port_1 (
    .addr     (A1),
    .regs     (regs_q),
`ifdef REGFILE_BYPASS_EN
    .byp_we   (byp_we),
    .byp_addr (A3),
    .byp_data (WD3),
`endif
    .rdata    (RD1)
  );

  regfile_read_port u_read_port_2 (
    .addr     (A2),
    .regs     (regs_q),
`ifdef REGFILE_BYPASS_EN
    .byp_we   (byp_we),
    .byp_addr (A3),
    .byp_data (WD3),
`endif
    .rdata    (RD2)
  );

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Self-checking bench for register_file. A table of
//                single-edge vectors (inputs + expected read data after the
//                edge) plus hand-written sequences for reset sweep, write
//                sweep and same-cycle read/write behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

  logic        clk;
  logic        reset;
  logic [4:0]  A1, A2, A3;
  logic        WE3;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2;

  int n_tests;
  int n_fail;

  register_file dut (
    .clk   (clk),
    .reset (reset),
    .A1    (A1),
    .A2    (A2),
    .A3    (A3),
    .WE3   (WE3),
    .WD3   (WD3),
    .RD1   (RD1),
    .RD2   (RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic drive(input logic r, input logic we, input logic [4:0] a3,
                       input logic [31:0] wd, input logic [4:0] a1,
                       input logic [4:0] a2);
    reset = r;
    WE3   = we;
    A3    = a3;
    WD3   = wd;
    A1    = a1;
    A2    = a2;
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  logic [31:0] exp_pre;

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //            rst we a3  wd            a1  a2  e1            e2
    vecs[0]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd8,  32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[3]  = '{1'b1, 1'b1, 5'd1,  32'd5,        5'd1,  5'd5,  32'd5,        32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b1, 5'd8,  32'd10,       5'd1,  5'd8,  32'd5,        32'd10};
    vecs[5]  = '{1'b1, 1'b0, 5'd1,  32'd99,       5'd1,  5'd8,  32'd5,        32'd10};
    vecs[6]  = '{1'b0, 1'b1, 5'd3,  32'd7,        5'd3,  5'd1,  32'h0,        32'h0};
    vecs[7]  = '{1'b1, 1'b1, 5'd3,  32'd7,        5'd3,  5'd3,  32'd7,        32'd7};
    vecs[8]  = '{1'b1, 1'b1, 5'd3,  32'd8,        5'd3,  5'd31, 32'd8,        32'h0};
    vecs[9]  = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd3,  5'd31, 32'd8,        32'hFFFFFFFF};
    vecs[10] = '{1'b1, 1'b1, 5'd3,  32'd9,        5'd3,  5'd31, 32'd9,        32'hFFFFFFFF};
    vecs[11] = '{1'b1, 1'b0, 5'd31, 32'h0,        5'd31, 5'd3,  32'hFFFFFFFF, 32'd9};

    // r0 reads zero even before any reset has been applied.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    check("r0_before_reset_rd1", RD1, 32'h0);
    check("r0_before_reset_rd2", RD2, 32'h0);

    // Table: inputs applied on the falling edge, outputs checked on the next
    // falling edge with the same inputs still held.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst_n, vecs[i].we, vecs[i].a3, vecs[i].wd,
            vecs[i].a1, vecs[i].a2);
      @(negedge clk);
      check($sformatf("vec%0d_rd1", i), RD1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), RD2, vecs[i].e2);
    end

    // Reset clears everything: write r5, reset one edge, sweep all addresses.
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      A1 = 5'(a);
      #1;
      check($sformatf("reset_sweep_a%0d", a), RD1, 32'h0);
    end
    @(negedge clk);

    // Single write then address sweep: only r8 holds data.
    drive(1'b1, 1'b1, 5'd8, 32'd10, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd8, 32'd10, 5'd0, 5'd0);
    for (int a = 1; a <= 14; a++) begin
      A1 = 5'(a);
      #1;
      check($sformatf("write_sweep_a%0d", a), RD1, (a == 8) ? 32'd10 : 32'h0);
    end
    @(negedge clk);

    // Same-cycle read of the write target.
    drive(1'b1, 1'b1, 5'd4, 32'h55, 5'd4, 5'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd4, 32'h1234, 5'd4, 5'd4);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h1234;
`else
    exp_pre = 32'h55;
`endif
    check("same_cycle_pre_rd1", RD1, exp_pre);
    check("same_cycle_pre_rd2", RD2, exp_pre);
    @(negedge clk);
    check("same_cycle_post_rd1", RD1, 32'h1234);

    // While reset is low nothing is forwarded; the edge then clears r4.
    drive(1'b0, 1'b1, 5'd4, 32'hAAAA, 5'd4, 5'd4);
    #1;
    check("reset_no_fwd_pre_rd1", RD1, 32'h1234);
    @(negedge clk);
    check("reset_no_fwd_post_rd1", RD1, 32'h0);

    // A write to r0 is never forwarded.
    drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    check("r0_no_fwd_rd1", RD1, 32'h0);
    check("r0_no_fwd_rd2", RD2, 32'h0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
